// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers; one start/done handshake.
// Optional build macro MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned W2    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz;
    // acc holds the product for MUL and {remainder, quotient} for DIV
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    // multiplier magnitude for MUL, divisor magnitude for DIV
    logic [WIDTH-1:0] mplier;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [W2-1:0]    mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [W2-1:0]    div_next;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Operand magnitudes and one iteration step of each datapath
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(-a) : a;
        b_mag     = b_neg ? WIDTH'(-b) : b;
        mul_sum   = acc + (mplier[0] ? mcand : '0);
        shifted   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        diff      = shifted - {1'b0, mplier};
        if (!diff[WIDTH]) begin
            div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        quo = acc[WIDTH-1:0];
        rem = acc[W2-1:WIDTH];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        cnt      <= CNT_W'(WIDTH);
                        is_div   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        mplier   <= b_mag;
                        dz       <= 1'b0;
                        if (!op[1]) begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                            state <= S_MUL;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, a_mag};
                            if (b == '0) begin
                                dz    <= 1'b1;
                                state <= S_FIX;
                            end else begin
                                state <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
`ifdef MDU_EARLY_TERM_EN
                    end else if (mplier[WIDTH-1:1] == '0) begin
                        state <= S_FIX;
`endif
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Sign correction and result write-back; div-by-zero leaves hi/lo untouched
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (dz) begin
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        lo <= neg_lo ? WIDTH'(-quo) : quo;
                        hi <= neg_hi ? WIDTH'(-rem) : rem;
                    end else begin
                        {hi, lo} <= neg_lo ? W2'(-acc) : acc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus randomized operations
// checked against a plain-arithmetic model (honours MDU_EARLY_TERM_EN for latency).
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           acc_cyc;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           nvec = 0;
    int           nfail = 0;
    logic         busy_bad = 1'b0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result and latency from the arithmetic definition of each op
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output exp_t e);
        longint       sx;
        longint       sy;
        longint       r64;
        logic [63:0]  p;
        logic [W-1:0] mag;
        int           iters;
        int           lat;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        lat  = W + 1;
        case (o)
            2'b00: begin r64 = sx * sy; p = r64; model_hi = p[63:32]; model_lo = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; model_hi = p[63:32]; model_lo = p[31:0]; end
            default: begin
                if (y == '0) begin
                    e.dz = 1'b1;
                    lat  = 1;
                end else if (o == 2'b10) begin
                    r64 = sx / sy; model_lo = r64[31:0];
                    r64 = sx % sy; model_hi = r64[31:0];
                end else begin
                    model_lo = x / y;
                    model_hi = x % y;
                end
            end
        endcase
`ifdef MDU_EARLY_TERM_EN
        if (!o[1]) begin
            mag = (o == 2'b00 && y[W-1]) ? -y : y;
            iters = 1;
            for (int i = 0; i < W; i++) if (mag[i]) iters = i + 1;
            lat = iters + 1;
        end
`endif
        e.hi = model_hi;
        e.lo = model_lo;
        e.done_cyc = lat;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   guard = 0;
        @(negedge clock);
        while (busy && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (busy) begin
            check("start_wait_busy", 64'(busy), 64'd0);
        end else begin
            model(o, x, y, e);
            e.acc_cyc  = cyc + 1;
            e.done_cyc = e.acc_cyc + e.done_cyc;
            sb.push_back(e);
            start = 1'b1; op = o; a = x; b = y;
            @(negedge clock);
            start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        end
    endtask

    // Monitor: pops the scoreboard on done, checks timing, results and the busy window
    always @(negedge clock) begin
        if (!reset) begin
            if (sb.size() > 0 && cyc >= sb[0].acc_cyc && cyc < sb[0].done_cyc && !busy)
                busy_bad = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    check("div_zero", 64'(div_zero), 64'(e.dz));
                    check("busy_in_done", 64'(busy), 64'd0);
                    check("busy_window", 64'(busy_bad), 64'd0);
                    busy_bad = 1'b0;
                end
            end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                check("done_timeout", 64'(cyc), 64'(sb[0].done_cyc));
                void'(sb.pop_front());
                busy_bad = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'h5678_1234, 32'h0001_0000);
        issue(2'b10, 32'd55, 32'd0);
        issue(2'b01, 32'd2, 32'd3);
        issue(2'b01, 32'd5, 32'd3);

        // Reset in the middle of a DIV clears everything and drops the pending result
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        sb.delete();
        busy_bad = 1'b0;
        model_hi = '0;
        model_lo = '0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        issue(2'b11, 32'd81, 32'd9);

        // start pulses while busy are dropped
        issue(2'b00, 32'h0001_2345, 32'hFFFF_0001);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        issue(2'b10, 32'h7FFF_FFFF, 32'h8000_0000);

        for (int n = 0; n < 150; n++) begin
            logic [1:0]   o;
            logic [W-1:0] x;
            logic [W-1:0] y;
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = 32'($urandom_range(0, 15));
                2: x = 32'h8000_0000;
                3: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            issue(o, x, y);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() > 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
